// File: rtl/stream_pkg.sv
// rtl/stream_pkg.sv - shared stream types and sizing helpers
//
// Purpose: common data width, data word type and the pointer-width helper
// used by sender_fifo and fifo_mem.
package stream_pkg;

  localparam int DATA_W_DEF = 8;

  typedef logic [DATA_W_DEF-1:0] data_t;

  // Index width for a power-of-two depth; pointers add one wrap bit on top.
  function automatic int clog2_depth(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - DEPTH x DATA_W register array, sync write, async read
//
// Ports:
//   clk    in   clock, write on posedge
//   we     in   write enable
//   waddr  in   write index
//   wdata  in   write data
//   raddr  in   read index
//   rdata  out  combinational read of mem[raddr]
module fifo_mem
  import stream_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 8,
  parameter int AW     = clog2_depth(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  // Storage is never reset: validity is tracked by the pointers upstream.
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sender_fifo.sv
// rtl/sender_fifo.sv - first-word-fall-through ready/valid FIFO ahead of the sender
//
// Ports:
//   clk          in   clock, all logic on posedge
//   rst          in   synchronous active-high reset
//   flush        in   synchronous clear of contents (rst wins)
//   in_data      in   write data
//   in_valid     in   write request
//   in_ready     out  FIFO can accept (not full)
//   out_data     out  head word, valid while out_valid=1
//   out_valid    out  head word valid (not empty)
//   out_ready    in   sender accepts head word
//   count        out  occupancy, 0..DEPTH
//   almost_full  out  count >= AF_LEVEL
//   overflow     out  sticky: write attempted while full, cleared by rst only
module sender_fifo
  import stream_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic [DATA_W-1:0]           in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [DATA_W-1:0]           out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [clog2_depth(DEPTH):0] count,
  output logic                        almost_full,
  output logic                        overflow
);

  localparam int AW = clog2_depth(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] count_q;
  logic          overflow_q;
  logic          empty;
  logic          full;
  logic          push;
  logic          pop;

  // Extra MSB distinguishes full from empty when the index bits match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

  // Flags come only from registered state, so no input reaches an output
  // combinationally.
  assign in_ready    = !full;
  assign out_valid   = !empty;
  assign count       = count_q;
  assign almost_full = (count_q >= PW'(AF_LEVEL));
  assign overflow    = overflow_q;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push && !flush),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (in_data),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (out_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      // A rejected write is recorded even in a flush cycle; flush never
      // clears the sticky flag.
      if (in_valid && !in_ready) begin
        overflow_q <= 1'b1;
      end

      if (flush) begin
        // Any push or pop coincident with flush is discarded.
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        count_q <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        case ({push, pop})
          2'b10:   count_q <= count_q + 1'b1;
          2'b01:   count_q <= count_q - 1'b1;
          default: count_q <= count_q;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sender_fifo.sv
// tb/tb_sender_fifo.sv - directed table-driven bench for sender_fifo
module tb_sender_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] count;
  logic       almost_full;
  logic       overflow;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sender_fifo dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .count       (count),
    .almost_full (almost_full),
    .overflow    (overflow)
  );

  typedef struct {
    logic       iv;
    logic [7:0] d;
    logic       ordy;
    logic [3:0] cnt;
    logic       ir;
    logic       ov;
    logic [7:0] od;
    logic       af;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int wi;
    int ri;
    int cyc;

    // State is checked before each edge, then the vector's inputs are clocked.
    vecs[0] = '{iv:1'b0, d:8'h00, ordy:1'b1, cnt:4'd0, ir:1'b1, ov:1'b0, od:8'h00, af:1'b0};
    vecs[1] = '{iv:1'b1, d:8'h11, ordy:1'b0, cnt:4'd0, ir:1'b1, ov:1'b0, od:8'h00, af:1'b0};
    vecs[2] = '{iv:1'b1, d:8'h22, ordy:1'b0, cnt:4'd1, ir:1'b1, ov:1'b1, od:8'h11, af:1'b0};
    vecs[3] = '{iv:1'b1, d:8'h33, ordy:1'b0, cnt:4'd2, ir:1'b1, ov:1'b1, od:8'h11, af:1'b0};
    vecs[4] = '{iv:1'b0, d:8'h00, ordy:1'b0, cnt:4'd3, ir:1'b1, ov:1'b1, od:8'h11, af:1'b0};
    vecs[5] = '{iv:1'b0, d:8'h00, ordy:1'b1, cnt:4'd3, ir:1'b1, ov:1'b1, od:8'h11, af:1'b0};
    vecs[6] = '{iv:1'b0, d:8'h00, ordy:1'b1, cnt:4'd2, ir:1'b1, ov:1'b1, od:8'h22, af:1'b0};
    vecs[7] = '{iv:1'b0, d:8'h00, ordy:1'b1, cnt:4'd1, ir:1'b1, ov:1'b1, od:8'h33, af:1'b0};
    vecs[8] = '{iv:1'b0, d:8'h00, ordy:1'b0, cnt:4'd0, ir:1'b1, ov:1'b0, od:8'h00, af:1'b0};

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state plus three-word push/pop.
    for (int i = 0; i < 9; i++) begin
      in_valid  = vecs[i].iv;
      in_data   = vecs[i].d;
      out_ready = vecs[i].ordy;
      check($sformatf("v%0d_count", i), count, vecs[i].cnt);
      check($sformatf("v%0d_in_ready", i), in_ready, vecs[i].ir);
      check($sformatf("v%0d_out_valid", i), out_valid, vecs[i].ov);
      check($sformatf("v%0d_almost_full", i), almost_full, vecs[i].af);
      check($sformatf("v%0d_overflow", i), overflow, 1'b0);
      if (vecs[i].ov) begin
        check($sformatf("v%0d_out_data", i), out_data, vecs[i].od);
      end
      step();
    end

    // Fill to full, watching almost_full from count 6.
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h80 + 8'(i);
      check($sformatf("fill%0d_count", i), count, i);
      check($sformatf("fill%0d_af", i), almost_full, (i >= 6));
      step();
    end
    in_data = 8'hAA;
    check("full_in_ready", in_ready, 1'b0);
    check("full_count", count, 4'd8);
    check("full_af", almost_full, 1'b1);
    step();
    check("full_overflow", overflow, 1'b1);
    check("full_count_hold", count, 4'd8);

    // Push while full together with a pop: only the pop happens.
    in_data   = 8'h55;
    out_ready = 1'b1;
    check("fullpop_in_ready", in_ready, 1'b0);
    check("fullpop_head", out_data, 8'h80);
    step();
    check("fullpop_count", count, 4'd7);
    check("fullpop_in_ready_after", in_ready, 1'b1);
    in_valid = 1'b0;
    for (int i = 1; i < 8; i++) begin
      check($sformatf("drain%0d_valid", i), out_valid, 1'b1);
      check($sformatf("drain%0d_data", i), out_data, 8'h80 + 8'(i));
      step();
    end
    check("drain_empty", out_valid, 1'b0);
    check("drain_count", count, 4'd0);

    // Flush after 5 words; a push in the flush cycle is dropped.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h40 + 8'(i);
      step();
    end
    check("preflush_count", count, 4'd5);
    flush   = 1'b1;
    in_data = 8'h99;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_count", count, 4'd0);
    check("flush_out_valid", out_valid, 1'b0);
    check("flush_in_ready", in_ready, 1'b1);
    check("flush_af", almost_full, 1'b0);
    check("flush_overflow_kept", overflow, 1'b1);
    in_valid = 1'b1;
    in_data  = 8'h5A;
    step();
    in_valid = 1'b0;
    check("postflush_count", count, 4'd1);
    check("postflush_data", out_data, 8'h5A);

    // Reset clears overflow and contents.
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_overflow", overflow, 1'b0);
    check("rst_count", count, 4'd0);
    check("rst_out_valid", out_valid, 1'b0);

    // Stream 20 words with out_ready toggling; order kept across wrap.
    wi  = 0;
    ri  = 0;
    cyc = 0;
    while (ri < 20 && cyc < 300) begin
      in_valid  = (wi < 20);
      in_data   = 8'(wi);
      out_ready = cyc[0];
      check($sformatf("stream_c%0d_count", cyc), count, 32'(wi - ri));
      if (out_valid && out_ready) begin
        check($sformatf("stream_r%0d_data", ri), out_data, 32'(ri));
        ri++;
      end
      if (in_ready && in_valid) begin
        wi++;
      end
      step();
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("stream_all_read", ri, 20);
    check("stream_empty", out_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
